// File: rtl/cnu_expand_if.sv
// Handshake bundle between the CNU merge-tree root, the expander and the VNU side.
// The master modport is the producer/consumer environment; slave is the expander.
interface cnu_expand_if #(
    parameter int unsigned data_w = 8,
    parameter int unsigned idx_w  = 8,
    parameter int unsigned deg    = 8,
    parameter int unsigned P      = 2
);
    logic                        in_valid;
    logic                        in_ready;
    logic [2*data_w-1:0]         min_in;
    logic [2*idx_w-1:0]          idx_in;
    logic [deg-1:0]              sign_in;
    logic                        out_valid;
    logic                        out_ready;
    logic [P*(data_w+1)-1:0]     out;
    logic [P-1:0]                out_en;
    logic [idx_w-1:0]            out_base;
    logic                        out_last;

    modport master (
        output in_valid, min_in, idx_in, sign_in, out_ready,
        input  in_ready, out_valid, out, out_en, out_base, out_last
    );

    modport slave (
        input  in_valid, min_in, idx_in, sign_in, out_ready,
        output in_ready, out_valid, out, out_en, out_base, out_last
    );
endinterface

// File: rtl/cnu_expand.sv
// Min-sum CNU output expander: turns one compressed row (min1/min2/idx1/signs)
// into ceil(deg/P) beats of P extrinsic {sign, magnitude} messages.
module cnu_expand #(
    parameter int unsigned data_w = 8,
    parameter int unsigned idx_w  = 8,
    parameter int unsigned deg    = 8,
    parameter int unsigned P      = 2,
    parameter int unsigned OFFSET = 0
) (
    input logic         clk,
    input logic         rst,
    cnu_expand_if.slave bus
);

    localparam int unsigned NB  = (deg + P - 1) / P;
    localparam int unsigned KW  = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned LW  = data_w + 1;
    localparam logic [data_w-1:0] OFF = data_w'(OFFSET);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t              state;
    logic [KW-1:0]       k;
    logic [data_w-1:0]   min1_q, min2_q;
    logic [idx_w-1:0]    idx1_q;
    logic [deg-1:0]      sign_q;
    logic                par_q;

    logic                acc, fire;
    logic [data_w-1:0]   min1_s, min2_s;
    logic [idx_w-1:0]    idx_s;
    logic [deg-1:0]      sign_s;
    logic                par_s;
    logic [KW-1:0]       k_s;

    logic [P*LW-1:0]     out_s;
    logic [P-1:0]        en_s;
    logic [idx_w-1:0]    base_s;
    logic                last_s;
    int unsigned         e;
    logic [data_w-1:0]   mag, mag_o;
    logic [deg-1:0]      sh;

    logic unused_idx_hi;
    assign unused_idx_hi = ^bus.idx_in[2*idx_w-1:idx_w];

    // A new row may enter in IDLE or on the cycle the last beat retires.
    always_comb begin
        fire         = bus.out_valid && bus.out_ready;
        bus.in_ready = (state == IDLE) || (fire && bus.out_last);
        acc          = bus.in_valid && bus.in_ready;
    end

    // Beat source: the incoming row on acceptance, otherwise the latched row at k+1.
    always_comb begin
        if (acc) begin
            min1_s = bus.min_in[data_w-1:0];
            min2_s = bus.min_in[2*data_w-1:data_w];
            idx_s  = bus.idx_in[idx_w-1:0];
            sign_s = bus.sign_in;
            par_s  = ^bus.sign_in;
            k_s    = '0;
        end else begin
            min1_s = min1_q;
            min2_s = min2_q;
            idx_s  = idx1_q;
            sign_s = sign_q;
            par_s  = par_q;
            k_s    = k + KW'(1);
        end
    end

    always_comb begin
        out_s = '0;
        en_s  = '0;
        e     = 0;
        mag   = '0;
        mag_o = '0;
        sh    = '0;
        for (int unsigned l = 0; l < P; l++) begin
            e = 32'(k_s) * P + l;
            if (e < deg) begin
                mag   = (32'(idx_s) == e) ? min2_s : min1_s;
                mag_o = (mag > OFF) ? mag - OFF : '0;
                sh    = sign_s >> e;
                out_s[LW*l +: LW] = {par_s ^ sh[0], mag_o};
                en_s[l] = 1'b1;
            end
        end
        base_s = idx_w'(32'(k_s) * P);
        last_s = (32'(k_s) == NB - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            min1_q       <= '0;
            min2_q       <= '0;
            idx1_q       <= '0;
            sign_q       <= '0;
            par_q        <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out      <= '0;
            bus.out_en   <= '0;
            bus.out_base <= '0;
            bus.out_last <= 1'b0;
        end else if (acc) begin
            state        <= EXPAND;
            k            <= k_s;
            min1_q       <= min1_s;
            min2_q       <= min2_s;
            idx1_q       <= idx_s;
            sign_q       <= sign_s;
            par_q        <= par_s;
            bus.out_valid <= 1'b1;
            bus.out      <= out_s;
            bus.out_en   <= en_s;
            bus.out_base <= base_s;
            bus.out_last <= last_s;
        end else if (fire) begin
            if (bus.out_last) begin
                state        <= IDLE;
                k            <= '0;
                bus.out_valid <= 1'b0;
                bus.out      <= '0;
                bus.out_en   <= '0;
                bus.out_base <= '0;
                bus.out_last <= 1'b0;
            end else begin
                k            <= k_s;
                bus.out      <= out_s;
                bus.out_en   <= en_s;
                bus.out_base <= base_s;
                bus.out_last <= last_s;
            end
        end
    end

endmodule

// File: doc/cnu_expand.md
# cnu_expand

Check-node output expander for the min-sum CNU. It accepts one compressed check-node result per row: min1/min2, the index of min1, and the per-edge input signs, as produced at the root of the merge tree. It serially regenerates the per-edge extrinsic messages, P edges per beat, back toward the variable-node side. It is the distribution half of the CNU and sits directly after the last merge stage.

## Interface

Parameters:
- data_w, 8, magnitude width of min1/min2 and of each output magnitude
- idx_w, 8, edge-index width
- deg, 8, check-node degree (edges per row), ≥ 2
- P, 2, output lanes per beat, 1 ≤ P ≤ deg
- OFFSET, 0, offset-min-sum correction subtracted from every output magnitude, saturating at 0

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  compressed result present
- in_ready  out  1  block accepts compressed result this cycle
- min_in  in  2*data_w  [data_w-1:0] = min1, [2*data_w-1:data_w] = min2; min1 ≤ min2 is guaranteed by the producer
- idx_in  in  2*idx_w  [idx_w-1:0] = edge index of min1; the upper half is ignored
- sign_in  in  deg  bit e = sign of incoming message on edge e (1 = negative)
- out_valid  out  1  beat present on out
- out_ready  in  1  downstream accepts beat
- out  out  P*(data_w+1)  lane l at [(data_w+1)*l +: data_w+1], format {sign, magnitude}
- out_en  out  P  lane l carries a real edge
- out_base  out  idx_w  edge index of lane 0 in this beat
- out_last  out  1  final beat of the row

## Operation

- States: IDLE, EXPAND.
- Input acceptance: when in_valid && in_ready, latch the following and enter EXPAND with beat counter k = 0:
  - min1, min2, idx1
  - sign vector
  - parity S = XOR of all sign_in bits
- in_ready is high in IDLE. It is also high in EXPAND during the cycle where out_valid && out_ready && out_last; a row accepted in that cycle starts at k = 0 with no bubble.
- Beats: NB = ceil(deg/P). Beat k covers edges e = k*P + l for l = 0..P-1.
- Lane l with e < deg:
  - out_en[l] = 1
  - mag = (e == idx1) ? min2 : min1
  - magnitude = (mag > OFFSET) ? mag − OFFSET : 0
  - sign = S ^ sign[e]
- Lane l with e ≥ deg: out_en[l] = 0 and the lane is all zeros.
- If idx1 ≥ deg, every real lane uses min1.
- out_base = k*P. out_last = (k == NB−1).
- Advance: on out_valid && out_ready, set k = k+1. On the last beat, go to IDLE, or stay in EXPAND with k = 0 if a new row is accepted in the same cycle.
- Backpressure: while out_valid && !out_ready, the following hold stable:
  - out, out_en, out_base, out_last
  - all latched state
- Arithmetic:
  - The offset subtract is data_w bits wide and unsigned, with no wrap.
  - The sign is never applied to a zero magnitude in any special way; a sign of 1 with magnitude 0 is legal.
- The k counter width is clog2(NB), with a minimum of 1.

## Timing

- Reset: when rst is high at a clock edge:
  - state = IDLE, k = 0
  - out_valid = 0, out = 0, out_en = 0, out_base = 0, out_last = 0
  - all latched fields = 0
- in_ready = 1 from the first cycle after rst deasserts.
- Reset mid-row discards the row; no partial beats appear afterward.
- Outputs are registered. A row accepted at edge T presents beat 0 with out_valid = 1 after T (latency 1 cycle).
- Each beat lasts ≥ 1 cycle. With out_ready held at 1, a row occupies exactly NB cycles and back-to-back rows stream with no idle cycle.
- out_valid falls after the last beat is accepted unless a new row was accepted in the same cycle.
- in_valid while in_ready = 0 is ignored; the producer holds it.
- Latched fields do not change during EXPAND except on a new acceptance.

## Test plan

- Basic expansion, deg=8, P=2, OFFSET=0. Stimulus: min1=3, min2=7, idx1=5, sign_in=8'b0000_0101 (S=0), out_ready=1. Required: 4 beats, beginning the cycle after acceptance.
  - out_base = 0, 2, 4, 6
  - Edges 0..7 magnitudes = 3,3,3,3,3,7,3,3
  - Signs = 1,0,1,0,0,0,0,0
  - out_last only on beat 3
- Backpressure: same stimulus, out_ready toggled 1,0,0,1,0,1,1. Required:
  - Beats are held unchanged while stalled.
  - Exactly 4 beats are accepted, in order.
  - in_ready stays 0 until the last beat handshake.
- Ragged degree, deg=5, P=2. Stimulus: min1=2, min2=9, idx1=0, sign_in=5'b10000 (S=1). Required: 3 beats.
  - Edge 0 = {1,9}, edges 1..3 = {1,2}, edge 4 = {0,2}
  - Beat 2: out_en = 2'b01, lane 1 = 0, out_last = 1
- Offset saturation, OFFSET=2. Stimulus: min1=1, min2=7, idx1=3. Required: edge 3 magnitude = 5, all other magnitudes = 0. With idx1=200 (≥ deg), all magnitudes = 0.
- Back-to-back rows, out_ready=1, in_valid held high with two rows. Required:
  - The second row's beat 0 immediately follows the first row's last beat, with no gap.
  - out_valid is continuous for 8 cycles.
- Reset mid-row: assert rst for 1 cycle during beat 1. Required:
  - The next cycle has out_valid = 0 and all outputs = 0, with in_ready = 1.
  - The next accepted row restarts at out_base = 0.
